// File: rtl/uart_tx_baud.sv
// uart_tx_baud: UART transmitter with an internal baud-enable counter, LSB-first start/data/[parity]/stop framing
module uart_tx_baud #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 internal_clk_fgpa,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  generate
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
      $error("uart_tx_baud: illegal parameter set");
    end
  endgenerate
  logic [2:0]           state;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par;
  logic                 bit_end;
  assign bit_end  = baud_cnt == CW'(CLKS_PER_BIT - 1);
  assign tx_ready = state == IDLE;
  assign busy     = state != IDLE;
  // tx is only ever loaded at bit boundaries, so the line is a clean register output
  always_ff @(posedge internal_clk_fgpa or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        if (tx_valid) begin
          state    <= START;
          tx       <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          shift    <= tx_data;
          par      <= (^tx_data) ^ (PARITY_ODD != 0);
        end
      end else if (!bit_end) begin
        baud_cnt <= baud_cnt + CW'(1);
      end else begin
        baud_cnt <= '0;
        case (state)
          START: begin
            state <= DATA;
            tx    <= shift[0];
            shift <= shift >> 1;
          end
          DATA: begin
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
              tx      <= (PARITY_EN != 0) ? par : 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end
          PARITY: begin
            state <= STOP;
            tx    <= 1'b1;
          end
          STOP: begin
            if (bit_cnt == 4'(STOP_BITS - 1)) begin
              state   <= IDLE;
              bit_cnt <= '0;
              tx_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_baud.sv
// tb_uart_tx_baud: directed table-driven bench for uart_tx_baud at 4 clocks per bit
module tb_uart_tx_baud;
  localparam int CPB = 4;
  typedef struct {
    int          idx;
    logic [7:0]  data;
    int          nb;
    logic [11:0] exp;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic [3:0] valid = '0;
  logic [3:0] txw, busyw, donew, readyw;
  int checks = 0;
  int passed = 0;
  vec_t vt[8];
  always #5 clk = ~clk;
  uart_tx_baud #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) d0 (
    .internal_clk_fgpa(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[0]),
    .tx_ready(readyw[0]), .tx(txw[0]), .busy(busyw[0]), .tx_done(donew[0]));
  uart_tx_baud #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) d1 (
    .internal_clk_fgpa(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[1]),
    .tx_ready(readyw[1]), .tx(txw[1]), .busy(busyw[1]), .tx_done(donew[1]));
  uart_tx_baud #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) d2 (
    .internal_clk_fgpa(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[2]),
    .tx_ready(readyw[2]), .tx(txw[2]), .busy(busyw[2]), .tx_done(donew[2]));
  uart_tx_baud #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) d3 (
    .internal_clk_fgpa(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[3]),
    .tx_ready(readyw[3]), .tx(txw[3]), .busy(busyw[3]), .tx_done(donew[3]));
  // status nibble per instance: {tx, busy, tx_done, tx_ready}
  function automatic logic [3:0] st(int i);
    return {txw[i], busyw[i], donew[i], readyw[i]};
  endfunction
  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: {tx,busy,done,ready} got %b want %b", name, act, exp);
  endtask
  // called just after the accept edge E; returns just after edge E+N
  task automatic expect_frame(int i, int nb, logic [11:0] exp, string name);
    for (int c = 0; c < nb * CPB; c++) begin
      chk($sformatf("%s cyc%0d", name, c), st(i), {exp[c / CPB], 3'b100});
      @(posedge clk); #1;
    end
    chk({name, " done"}, st(i), 4'b1011);
  endtask
  task automatic send(int i, logic [7:0] d, int nb, logic [11:0] exp, string name);
    @(negedge clk);
    tx_data  = d;
    valid[i] = 1'b1;
    @(posedge clk); #1;
    valid[i] = 1'b0;
    expect_frame(i, nb, exp, name);
    @(posedge clk); #1;
    chk({name, " idle"}, st(i), 4'b1001);
  endtask
  initial begin
    vt[0] = '{0, 8'hA5, 10, 12'({1'b1, 8'hA5, 1'b0})};
    vt[1] = '{1, 8'h07, 11, 12'({1'b1, 1'b1, 8'h07, 1'b0})};
    vt[2] = '{2, 8'h07, 11, 12'({1'b1, 1'b0, 8'h07, 1'b0})};
    vt[3] = '{3, 8'h07, 12, 12'({2'b11, 1'b1, 8'h07, 1'b0})};
    vt[4] = '{1, 8'h00, 11, 12'({1'b1, 1'b0, 8'h00, 1'b0})};
    vt[5] = '{2, 8'h00, 11, 12'({1'b1, 1'b1, 8'h00, 1'b0})};
    vt[6] = '{0, 8'h3C, 10, 12'({1'b1, 8'h3C, 1'b0})};
    vt[7] = '{3, 8'h81, 12, 12'({2'b11, 1'b0, 8'h81, 1'b0})};
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("in reset d%0d", i), st(i), 4'b1001);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) chk($sformatf("after reset d%0d", i), st(i), 4'b1001);
    for (int v = 0; v < 8; v++) send(vt[v].idx, vt[v].data, vt[v].nb, vt[v].exp, $sformatf("vec%0d", v));
    // back-to-back with tx_valid held: second start bit at E+41
    @(negedge clk);
    tx_data  = 8'h00;
    valid[0] = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'hFF;
    expect_frame(0, 10, 12'({1'b1, 8'h00, 1'b0}), "b2b first");
    @(posedge clk); #1;
    valid[0] = 1'b0;
    expect_frame(0, 10, 12'({1'b1, 8'hFF, 1'b0}), "b2b second");
    @(posedge clk); #1;
    chk("b2b idle", st(0), 4'b1001);
    // data change during data bit 2 and valid drop while busy are both ignored
    @(negedge clk);
    tx_data  = 8'h5A;
    valid[0] = 1'b1;
    @(posedge clk); #1;
    fork
      expect_frame(0, 10, 12'({1'b1, 8'h5A, 1'b0}), "busy 5A");
      begin
        repeat (13) @(posedge clk);
        #2 tx_data = 8'hC3;
        repeat (10) @(posedge clk);
        #2 valid[0] = 1'b0;
      end
    join
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk($sformatf("busy no C3 cyc%0d", c), st(0), 4'b1001);
    end
    // reset during data bit 3 of 0xF0
    @(negedge clk);
    tx_data  = 8'hF0;
    valid[0] = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("F0 data bit3", st(0), 4'b0100);
    #1 rst_n = 1'b0;
    #1;
    chk("mid-frame reset", st(0), 4'b1001);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post reset idle cyc%0d", c), st(0), 4'b1001);
    end
    send(0, 8'h3C, 10, 12'({1'b1, 8'h3C, 1'b0}), "after reset 3C");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
